gmii_mdio_master: RTL and testbench
===================================

# gmii_mdio_master

IEEE 802.3 Clause 22 station-management master that sequences MDIO read and write frames toward the GMII PHY. It sits beside the MAC, driving the PHY's MDC/MDIO management pins. It accepts one register access at a time from the MAC configuration logic over a valid/ready handshake and returns read data with a one-cycle response strobe.

## Interface
- MDC_DIV, 10, MDC half-period in sig_CLK cycles (≥1); MDC frequency = f(sig_CLK)/(2·MDC_DIV)
- sig_CLK  input  1  system clock; all logic rising-edge
- sig_RESET  input  1  asynchronous, active-high reset
- sig_REQ_VALID  input  1  access request
- sig_REQ_READY  output  1  high only in IDLE; transfer on VALID&READY
- sig_REQ_WRITE  input  1  1 = write (OP 01), 0 = read (OP 10)
- sig_REQ_PHYAD  input  5  PHY address
- sig_REQ_REGAD  input  5  register address
- sig_REQ_WDATA  input  16  write data
- sig_RSP_VALID  output  1  one-cycle pulse at end of every access
- sig_RSP_RDATA  output  16  read data; held until next read completes
- sig_RSP_ERR  output  1  read TA fault; valid with sig_RSP_VALID
- sig_MDCLK  output  1  MDC to PHY
- sig_MDIO_O / sig_MDIO_OE  output  1 each  MDIO drive value / enable; top level builds the inout
- sig_MDIO_I  input  1  MDIO pad input

## Operation
- Request fields are latched into a 64-bit shift register on acceptance; frame: 32×'1' preamble, ST=01, OP, PHYAD, REGAD, TA, 16 data bits, all MSB first.
- FSM: IDLE → PRE (32 bits) → HDR (ST+OP+PHYAD+REGAD, 14 bits) → TA (2 bits) → DATA (16 bits) → DONE → IDLE. A 6-bit counter tracks the bit index within each state.
- Write: master drives all 64 bits, TA = 10.
- Read: OE drops at the start of TA and stays low through DATA. TA bit 2 is sampled; a value ≠0 sets ERR. DATA bits are shifted into sig_RSP_RDATA, and the register is updated even on ERR.
- DONE lasts one cycle: RSP_VALID=1, OE=0. READY returns in the following cycle (IDLE).
- Requests presented while busy are stalled by READY=0 and are not dropped.
- Reset is asynchronous at any point, including mid-frame. The frame is abandoned with no RSP_VALID. Reset values:
  - READY=1, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0
  - MDCLK=0, MDIO_O=1, OE=0

## Timing
- Each MDIO bit occupies 2·MDC_DIV cycles: MDC low for MDC_DIV cycles, then high for MDC_DIV cycles.
- MDIO_O and OE change only on the cycle MDC goes low; that is the start of each bit.
- sig_MDIO_I is sampled on the cycle MDC goes high.
- MDC idles low in IDLE/DONE. The first low phase starts the cycle after acceptance.
- Full frame: 64·2·MDC_DIV cycles from acceptance to the last bit end, plus 1 cycle to RSP_VALID.
- No MDC edge is generated outside a frame.

## Configuration
- MDIO_PREAMBLE_SUPPRESS_EN defined:
  - Adds input sig_REQ_NO_PRE (1 bit), latched on acceptance.
  - When it is 1, PRE is skipped and the frame is 32 bits, 32·2·MDC_DIV cycles.
- Undefined: port absent; preamble always sent.

## Structure
- Package mdio_pkg holds:
  - ST=2'b01, OP_WR=2'b01, OP_RD=2'b10, TA_WR=2'b10
  - PRE_LEN=32, HDR_LEN=14, TA_LEN=2, DATA_LEN=16
  - FSM state enum
- Sub-module mdio_clk_gen: MDC_DIV counter producing sig_MDCLK plus one-cycle strobes bit_start (MDC falling) and sample (MDC rising), enabled by the FSM.

## Test plan
- MDC_DIV=2, write PHYAD=1, REGAD=0, WDATA=0x1140 → MDIO stream 32×1, 0101, 00001, 00000, 10, 0x1140; 256 cycles to RSP_VALID, ERR=0, OE high throughout.
- Read PHYAD=1, REGAD=2; PHY model drives TA=Z0, data 0x0141 → RSP_RDATA=0x0141, ERR=0, OE low from TA to end.
- Read with no PHY responding (bench pull-up) → RSP_RDATA=0xFFFF, ERR=1, RSP_VALID one cycle.
- VALID held high for two back-to-back requests → second accepted exactly one cycle after first RSP_VALID; READY low in between.
- Assert sig_RESET during DATA bit 5 → MDCLK=0, OE=0, MDIO_O=1 immediately; no RSP_VALID; next request runs a full 64-bit frame.
- With MDIO_PREAMBLE_SUPPRESS_EN and NO_PRE=1, write → frame starts with ST=01; 128 cycles (MDC_DIV=2) to RSP_VALID.

Source files
------------

// File: rtl/mdio_pkg.sv
// -----------------------------------------------------------------------------
// mdio_pkg
// Shared constants, FSM state type and frame builder for the Clause 22
// MDIO management master.
//   ST / OP_WR / OP_RD / TA_WR : fixed frame field codes
//   PRE_LEN .. DATA_LEN        : bit lengths of each frame section
//   state_t                    : sequencing FSM state encoding
//   build_frame()              : assembles the 64-bit MSB-first MDIO frame
// -----------------------------------------------------------------------------
package mdio_pkg;

    localparam logic [1:0] ST    = 2'b01;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] TA_WR = 2'b10;

    localparam int PRE_LEN  = 32;
    localparam int HDR_LEN  = 14;
    localparam int TA_LEN   = 2;
    localparam int DATA_LEN = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA,
        S_DONE
    } state_t;

    // Reads carry all-ones in TA/data so the (undriven) output stays at idle level.
    function automatic logic [63:0] build_frame(
        input logic        write,
        input logic [4:0]  phyad,
        input logic [4:0]  regad,
        input logic [15:0] wdata
    );
        if (write)
            return {32'hFFFF_FFFF, ST, OP_WR, phyad, regad, TA_WR, wdata};
        else
            return {32'hFFFF_FFFF, ST, OP_RD, phyad, regad, 2'b11, 16'hFFFF};
    endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// -----------------------------------------------------------------------------
// mdio_clk_gen
// Generates MDC from the system clock while enabled: MDC_DIV cycles low, then
// MDC_DIV cycles high per MDIO bit. MDC is held low with the divider cleared
// whenever en is low, so no MDC edge appears outside a frame.
// Ports:
//   clk, rst   : system clock, asynchronous active-high reset
//   en         : frame in progress
//   mdc        : MDC output (registered)
//   bit_start  : high in the last cycle of a bit; the edge ending it drops MDC
//                and begins the next bit
//   sample     : high in the last low cycle of a bit; the edge ending it raises
//                MDC and is where MDIO input is captured
// -----------------------------------------------------------------------------
module mdio_clk_gen #(
    parameter int unsigned MDC_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic mdc,
    output logic bit_start,
    output logic sample
);

    localparam logic [15:0] LAST = 16'(MDC_DIV - 1);

    logic [15:0] cnt;
    logic        phase_end;

    assign phase_end = (cnt == LAST);
    assign sample    = en && !mdc && phase_end;
    assign bit_start = en &&  mdc && phase_end;

    // NOTE: non-blocking (<=) for all clocked state so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            mdc <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            mdc <= 1'b0;
        end else if (phase_end) begin
            cnt <= '0;
            mdc <= ~mdc;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/gmii_mdio_master.sv
// -----------------------------------------------------------------------------
// gmii_mdio_master
// IEEE 802.3 Clause 22 MDIO master. Accepts one register access over a
// valid/ready handshake, shifts out the MDIO frame MSB first, and for reads
// releases MDIO from TA onward and captures the 16 data bits.
// Parameters:
//   MDC_DIV           : MDC half-period in sig_CLK cycles (>= 1)
// Optional build macro:
//   MDIO_PREAMBLE_SUPPRESS_EN : adds sig_REQ_NO_PRE; when set on a request the
//                               32-bit preamble is skipped
// Ports:
//   sig_CLK, sig_RESET        : clock, asynchronous active-high reset
//   sig_REQ_*                 : request handshake and fields
//   sig_RSP_VALID/RDATA/ERR   : one-cycle completion strobe, read data, TA fault
//   sig_MDCLK                 : MDC to PHY
//   sig_MDIO_O/OE/I           : MDIO drive value, drive enable, pad input
// -----------------------------------------------------------------------------
module gmii_mdio_master
    import mdio_pkg::*;
#(
    parameter int unsigned MDC_DIV = 10
) (
    input  logic        sig_CLK,
    input  logic        sig_RESET,
    input  logic        sig_REQ_VALID,
    output logic        sig_REQ_READY,
    input  logic        sig_REQ_WRITE,
    input  logic [4:0]  sig_REQ_PHYAD,
    input  logic [4:0]  sig_REQ_REGAD,
    input  logic [15:0] sig_REQ_WDATA,
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    input  logic        sig_REQ_NO_PRE,
`endif
    output logic        sig_RSP_VALID,
    output logic [15:0] sig_RSP_RDATA,
    output logic        sig_RSP_ERR,
    output logic        sig_MDCLK,
    output logic        sig_MDIO_O,
    output logic        sig_MDIO_OE,
    input  logic        sig_MDIO_I
);

    state_t      state, state_nx;
    logic [5:0]  bit_cnt, bit_cnt_nx, last_idx;
    logic        accept, in_frame, last_bit;
    logic        bit_start, sample;
    logic        req_no_pre;
    logic        is_write;
    logic [63:0] frame_new, frame_load;
    logic [62:0] sr;       // bits still to be sent after the one on MDIO_O
    logic [15:0] rx;       // read data being assembled
    logic        ta_err;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    assign req_no_pre = sig_REQ_NO_PRE;
`else
    assign req_no_pre = 1'b0;
`endif

    assign accept        = sig_REQ_VALID && (state == S_IDLE);
    assign in_frame      = state inside {S_PRE, S_HDR, S_TA, S_DATA};
    assign sig_REQ_READY = (state == S_IDLE);
    assign sig_RSP_VALID = (state == S_DONE);

    // Without preamble the frame begins at ST, so the low 32 bits move to the top.
    assign frame_new  = build_frame(sig_REQ_WRITE, sig_REQ_PHYAD, sig_REQ_REGAD, sig_REQ_WDATA);
    assign frame_load = req_no_pre ? {frame_new[31:0], 32'hFFFF_FFFF} : frame_new;

    mdio_clk_gen #(
        .MDC_DIV   (MDC_DIV)
    ) u_clk_gen (
        .clk       (sig_CLK),
        .rst       (sig_RESET),
        .en        (in_frame),
        .mdc       (sig_MDCLK),
        .bit_start (bit_start),
        .sample    (sample)
    );

    always_comb begin
        last_idx = '0;
        case (state)
            S_PRE:   last_idx = 6'(PRE_LEN - 1);
            S_HDR:   last_idx = 6'(HDR_LEN - 1);
            S_TA:    last_idx = 6'(TA_LEN - 1);
            S_DATA:  last_idx = 6'(DATA_LEN - 1);
            default: last_idx = '0;
        endcase
    end

    assign last_bit = (bit_cnt == last_idx);

    // NOTE: defaults first so every path assigns the next-state signals and no latch is inferred.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx   = req_no_pre ? S_HDR : S_PRE;
                    bit_cnt_nx = '0;
                end
            end
            S_PRE, S_HDR, S_TA, S_DATA: begin
                if (bit_start) begin
                    if (last_bit) begin
                        bit_cnt_nx = '0;
                        case (state)
                            S_PRE:   state_nx = S_HDR;
                            S_HDR:   state_nx = S_TA;
                            S_TA:    state_nx = S_DATA;
                            default: state_nx = S_DONE;
                        endcase
                    end else begin
                        bit_cnt_nx = bit_cnt + 6'd1;
                    end
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge sig_CLK or posedge sig_RESET) begin
        if (sig_RESET) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
        end
    end

    always_ff @(posedge sig_CLK or posedge sig_RESET) begin
        if (sig_RESET) begin
            sr            <= '0;
            rx            <= '0;
            ta_err        <= 1'b0;
            is_write      <= 1'b0;
            sig_MDIO_O    <= 1'b1;
            sig_MDIO_OE   <= 1'b0;
            sig_RSP_RDATA <= '0;
            sig_RSP_ERR   <= 1'b0;
        end else begin
            if (accept) begin
                // First bit goes out on the same edge that starts the first MDC low phase.
                sr          <= frame_load[62:0];
                sig_MDIO_O  <= frame_load[63];
                sig_MDIO_OE <= 1'b1;
                is_write    <= sig_REQ_WRITE;
                ta_err      <= 1'b0;
            end else if (bit_start) begin
                if (state == S_DATA && last_bit) begin
                    sig_MDIO_O  <= 1'b1;
                    sig_MDIO_OE <= 1'b0;
                    if (!is_write) begin
                        sig_RSP_RDATA <= rx;
                        sig_RSP_ERR   <= ta_err;
                    end else begin
                        sig_RSP_ERR   <= 1'b0;
                    end
                end else begin
                    sig_MDIO_O <= sr[62];
                    sr         <= {sr[61:0], 1'b1};
                    // Reads hand the bus to the PHY from the first TA bit.
                    if (state == S_HDR && last_bit && !is_write)
                        sig_MDIO_OE <= 1'b0;
                end
            end

            if (sample) begin
                // Only the second TA bit is defined (PHY drives 0); first is Z.
                if (state == S_TA && bit_cnt == 6'd1)
                    ta_err <= sig_MDIO_I;
                if (state == S_DATA)
                    rx <= {rx[14:0], sig_MDIO_I};
            end
        end
    end

endmodule

// File: tb/tb_gmii_mdio_master.sv
// -----------------------------------------------------------------------------
// tb_gmii_mdio_master
// Self-checking bench for gmii_mdio_master (MDC_DIV = 2). A transaction-level
// model predicts, cycle by cycle from the acceptance point, MDC, MDIO drive,
// OE, READY, RSP_VALID, RSP_RDATA and RSP_ERR. A PHY model answers reads
// (TA = Z0 or a faulty TA bit, 16 data bits) or stays silent behind a pull-up.
// Honors MDIO_PREAMBLE_SUPPRESS_EN when defined.
// -----------------------------------------------------------------------------
module tb_gmii_mdio_master;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic        write = 1'b0;
    logic [4:0]  phyad = '0;
    logic [4:0]  regad = '0;
    logic [15:0] wdata = '0;
    logic        req_no_pre = 1'b0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        mdc;
    logic        mdio_o;
    logic        oe;
    logic        mdio_i;

    always #5 clk = ~clk;

    gmii_mdio_master #(
        .MDC_DIV       (D)
    ) dut (
        .sig_CLK       (clk),
        .sig_RESET     (rst),
        .sig_REQ_VALID (valid),
        .sig_REQ_READY (ready),
        .sig_REQ_WRITE (write),
        .sig_REQ_PHYAD (phyad),
        .sig_REQ_REGAD (regad),
        .sig_REQ_WDATA (wdata),
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        .sig_REQ_NO_PRE(req_no_pre),
`endif
        .sig_RSP_VALID (rsp_valid),
        .sig_RSP_RDATA (rsp_rdata),
        .sig_RSP_ERR   (rsp_err),
        .sig_MDCLK     (mdc),
        .sig_MDIO_O    (mdio_o),
        .sig_MDIO_OE   (oe),
        .sig_MDIO_I    (mdio_i)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // PHY behaviour for the next accepted request
    bit          cfg_present = 1'b1;
    bit          cfg_ta2     = 1'b0;
    logic [15:0] cfg_data    = '0;

    // Transaction model
    int          cyc = 0;
    bit          m_active = 1'b0;
    int          m_k = 0;
    int          m_len = 0;
    int          m_off = 0;
    bit          m_wr = 1'b0;
    logic [63:0] m_frame = '0;
    bit          m_present = 1'b0;
    bit          m_pta2 = 1'b0;
    logic [15:0] m_pdata = '0;
    logic [15:0] m_rdata = '0;
    bit          m_err = 1'b0;

    // Observation helpers
    logic [63:0] cap = '0;
    int          oe_cnt = 0;
    logic        prev_mdc = 1'b0;
    int          last_rsp_cyc = 0;

    always @(posedge clk) begin
        int   e_j;
        logic e_mdc, e_oe;
        cyc++;
        if (rst) begin
            m_active = 1'b0;
            m_rdata  = '0;
            m_err    = 1'b0;
        end else if (!m_active) begin
            if (valid) begin
                m_active  = 1'b1;
                m_k       = 0;
                m_wr      = write;
                m_off     = req_no_pre ? 32 : 0;
                m_len     = (64 - m_off) * 2 * D;
                m_frame   = {32'hFFFF_FFFF, 2'b01, (write ? 2'b01 : 2'b10), phyad, regad, 2'b10, wdata};
                m_present = cfg_present;
                m_pta2    = cfg_ta2;
                m_pdata   = cfg_data;
                cap       = '0;
                oe_cnt    = 0;
            end
        end else begin
            m_k++;
            if (m_k == m_len) begin
                if (m_wr) begin
                    m_err = 1'b0;
                end else begin
                    m_rdata = m_present ? m_pdata : 16'hFFFF;
                    m_err   = m_present ? m_pta2 : 1'b1;
                end
            end
            if (m_k == m_len + 1) m_active = 1'b0;
        end

        #1;
        if (m_active && m_k < m_len) begin
            e_j   = m_k / (2 * D) + m_off;
            e_mdc = ((m_k % (2 * D)) >= D);
            e_oe  = m_wr || (e_j < 46);
            check("ctrl_frame", {ready, rsp_valid, mdc, oe}, {1'b0, 1'b0, e_mdc, e_oe});
            if (e_oe) check("mdio_o_frame", mdio_o, m_frame[63 - e_j]);
        end else if (m_active) begin
            check("ctrl_done", {ready, rsp_valid, mdc, oe}, 4'b0100);
            check("mdio_o_done", mdio_o, 1'b1);
            check("rsp_err", rsp_err, m_err);
        end else begin
            check("ctrl_idle", {ready, rsp_valid, mdc, oe}, 4'b1000);
            check("mdio_o_idle", mdio_o, 1'b1);
        end
        check("rsp_rdata", rsp_rdata, m_rdata);

        if (rsp_valid) last_rsp_cyc = cyc;
        if (mdc && !prev_mdc) cap = {cap[62:0], mdio_o};
        prev_mdc = mdc;
        if (oe) oe_cnt++;
    end

    // PHY model: updates mid-cycle, well clear of the MDC-rising sample edge
    logic phy_drv = 1'b0;
    logic phy_bit = 1'b1;

    always @(negedge clk) begin
        int j;
        phy_drv = 1'b0;
        phy_bit = 1'b1;
        if (m_active && !m_wr && m_present && m_k < m_len) begin
            j = m_k / (2 * D) + m_off;
            if (j == 47) begin
                phy_drv = 1'b1;
                phy_bit = m_pta2;
            end else if (j >= 48) begin
                phy_drv = 1'b1;
                phy_bit = m_pdata[63 - j];
            end
        end
    end

    assign mdio_i = oe ? mdio_o : (phy_drv ? phy_bit : 1'b1);

    task automatic request(input bit wr, input logic [4:0] pa, input logic [4:0] ra,
                           input logic [15:0] wd, input bit np, input bit pres,
                           input bit ta2, input logic [15:0] pd, input bit hold,
                           output int acc_cyc);
        bit got = 1'b0;
        @(negedge clk);
        write       = wr;
        phyad       = pa;
        regad       = ra;
        wdata       = wd;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        req_no_pre  = np;
`else
        req_no_pre  = 1'b0;
        if (np) req_no_pre = 1'b0;
`endif
        cfg_present = pres;
        cfg_ta2     = ta2;
        cfg_data    = pd;
        valid       = 1'b1;
        for (int t = 0; t < 5000; t++) begin
            if (ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("req_accepted", got, 1'b1);
        @(posedge clk);
        #2;
        acc_cyc = cyc;
        if (!hold) begin
            @(negedge clk);
            valid = 1'b0;
        end
    endtask

    task automatic wait_rsp(output int rsp_cyc);
        bit got = 1'b0;
        for (int t = 0; t < 20000; t++) begin
            @(posedge clk);
            #2;
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("rsp_valid_seen", got, 1'b1);
        rsp_cyc = cyc;
    endtask

    int a1, a2, r1, r2;
    bit rw, rnp, rpres, rta2;
    logic [4:0]  rpa, rra;
    logic [15:0] rwd, rpd;

    initial begin
        bit hit;
        #1 rst = 1'b1;
        #2;
        check("reset_ready",     ready,     1'b1);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rdata",     rsp_rdata, 16'h0000);
        check("reset_err",       rsp_err,   1'b0);
        check("reset_mdc",       mdc,       1'b0);
        check("reset_mdio_o",    mdio_o,    1'b1);
        check("reset_oe",        oe,        1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Write PHY 1 reg 0 = 0x1140
        request(1'b1, 5'd1, 5'd0, 16'h1140, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, a1);
        wait_rsp(r1);
        check("write_latency", r1 - a1, 256);
        check("write_err", rsp_err, 1'b0);
        check("write_stream_hi", cap[63:32], 32'hFFFF_FFFF);
        check("write_stream_lo", cap[31:0], 32'h5082_1140);
        check("write_oe_cycles", oe_cnt, 256);

        // Read PHY 1 reg 2, PHY answers 0x0141
        request(1'b0, 5'd1, 5'd2, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0141, 1'b0, a1);
        wait_rsp(r1);
        check("read_latency", r1 - a1, 256);
        check("read_rdata", rsp_rdata, 16'h0141);
        check("read_err", rsp_err, 1'b0);
        check("read_oe_cycles", oe_cnt, 184);

        // Read with no PHY: pull-up everywhere
        request(1'b0, 5'd7, 5'd3, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, a1);
        wait_rsp(r1);
        check("nophy_rdata", rsp_rdata, 16'hFFFF);
        check("nophy_err", rsp_err, 1'b1);
        @(posedge clk);
        #2;
        check("nophy_rsp_one_cycle", rsp_valid, 1'b0);

        // Back-to-back with VALID held
        request(1'b1, 5'd2, 5'd4, 16'hBEEF, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, a1);
        request(1'b1, 5'd3, 5'd5, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, a2);
        check("b2b_accept_gap", a2 - last_rsp_cyc, 2);
        wait_rsp(r2);
        check("b2b_second_latency", r2 - a2, 256);

        // Reset during DATA bit 5 of a read
        request(1'b0, 5'd1, 5'd1, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h5A5A, 1'b0, a1);
        hit = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (m_active && (m_k / (2 * D) + m_off) == 53) begin
                hit = 1'b1;
                break;
            end
        end
        check("reached_data_bit5", hit, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("midrst_mdc",       mdc,       1'b0);
        check("midrst_oe",        oe,        1'b0);
        check("midrst_mdio_o",    mdio_o,    1'b1);
        check("midrst_ready",     ready,     1'b1);
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        request(1'b1, 5'd9, 5'd10, 16'hC0DE, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, a1);
        wait_rsp(r1);
        check("post_reset_latency", r1 - a1, 256);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        // Preamble suppressed write
        request(1'b1, 5'd3, 5'd4, 16'hA5C3, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, a1);
        wait_rsp(r1);
        check("nopre_latency", r1 - a1, 128);
        check("nopre_stream", cap[31:0], 32'h5192_A5C3);
`endif

        // Randomized accesses
        for (int n = 0; n < 8; n++) begin
            rw    = 1'($urandom_range(0, 1));
            rpa   = 5'($urandom);
            rra   = 5'($urandom);
            rwd   = 16'($urandom);
            rpd   = 16'($urandom);
            rnp   = 1'($urandom_range(0, 1));
            rpres = ($urandom_range(0, 3) != 0);
            rta2  = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            request(rw, rpa, rra, rwd, rnp, rpres, rta2, rpd, 1'b0, a1);
            wait_rsp(r1);
            check("rand_latency", r1 - a1, (req_no_pre ? 64 : 128) * D);
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
